// File: rtl/shift_pkg.sv
// shift_pkg: op encodings, FSM states and default widths for iter_shift_unit.
package shift_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SHAMT_W = 5;
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: one-bit shift/rotate of a value; rotates exist only with ITER_SHIFT_ROTATE_EN.
module shift_step import shift_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_comb begin
`ifdef ITER_SHIFT_ROTATE_EN
    q = op == OP_SLL ? {d[WIDTH-2:0], 1'b0} :
        op == OP_SRL ? {1'b0, d[WIDTH-1:1]} :
        op == OP_SRA ? {d[WIDTH-1], d[WIDTH-1:1]} :
        op == OP_ROL ? {d[WIDTH-2:0], d[WIDTH-1]} :
        op == OP_ROR ? {d[0], d[WIDTH-1:1]} : d;
`else
    q = op == OP_SLL ? {d[WIDTH-2:0], 1'b0} :
        op == OP_SRL ? {1'b0, d[WIDTH-1:1]} :
        op == OP_SRA ? {d[WIDTH-1], d[WIDTH-1:1]} : d;
`endif
  end
endmodule

// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multicycle shifter, one bit per clock under start/busy/done.
// Optional rotates (op 100/101) enabled by ITER_SHIFT_ROTATE_EN.
module iter_shift_unit import shift_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out
);
  state_t state, state_n;
  logic [SHAMT_W-1:0] count, count_n;
  logic [2:0] op_r, op_n;
  logic [WIDTH-1:0] data_n, stepped;

  shift_step #(.WIDTH(WIDTH)) u_step (.op(op_r), .d(data_out), .q(stepped));

  assign busy = state != IDLE;
  assign done = state == DONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      op_r <= OP_NOP;
      data_out <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      op_r <= op_n;
      data_out <= data_n;
    end
  end

  // count is tested for zero before decrementing, so it never wraps
  always_comb begin
    state_n = state;
    count_n = count;
    op_n = op_r;
    data_n = data_out;
    if (state == IDLE && start) begin
      state_n = SHIFT;
      count_n = shamt;
      op_n = op;
      data_n = data_in;
    end else if (state == SHIFT) begin
      if (count == '0) state_n = DONE;
      else begin
        data_n = stepped;
        count_n = count - 1'b1;
      end
    end else if (state == DONE) state_n = IDLE;
  end
endmodule

// File: tb/tb_iter_shift_unit.sv
// tb_iter_shift_unit: directed table, corner sequences and random ops against an arithmetic model.
module tb_iter_shift_unit;
  logic clk = 0, reset = 1, start = 0, busy, done;
  logic [2:0] op = 0;
  logic [31:0] data_in = 0, data_out;
  logic [4:0] shamt = 0;
  int checks = 0, errors = 0;

  iter_shift_unit dut (.clk(clk), .reset(reset), .start(start), .op(op), .data_in(data_in),
                       .shamt(shamt), .busy(busy), .done(done), .data_out(data_out));

  always #5 clk = ~clk;

  typedef struct {logic [2:0] op; logic [31:0] d; logic [4:0] sh; logic [31:0] exp;} vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] d, input int n);
    logic [63:0] dd;
    logic [31:0] r;
    r = d;
    if (o == 3'd1) r = d << n;
    else if (o == 3'd2) r = d >> n;
    else if (o == 3'd3) r = $signed(d) >>> n;
`ifdef ITER_SHIFT_ROTATE_EN
    else if (o == 3'd4) begin
      dd = {d, d} << n;
      r = dd[63:32];
    end else if (o == 3'd5) begin
      dd = {d, d} >> n;
      r = dd[31:0];
    end
`endif
    return r;
  endfunction

  task automatic run(input logic [2:0] o, input logic [31:0] d, input logic [4:0] s,
                     input logic [31:0] exp, input string nm);
    int lat, bad;
    lat = 0;
    bad = 0;
    @(negedge clk);
    op = o; data_in = d; shamt = s; start = 1;
    @(negedge clk);
    start = 0; op = 3'($urandom); data_in = $urandom; shamt = 5'($urandom);
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (!busy) bad++;
      if (done) lat = k;
    end
    chk({nm, " latency"}, lat, s + 1);
    chk({nm, " busy"}, bad, 0);
    chk({nm, " data"}, data_out, exp);
    @(posedge clk);
    #1;
    chk({nm, " idle"}, {busy, done}, 0);
    chk({nm, " hold"}, data_out, exp);
  endtask

  initial begin
    int pulses;
    logic [2:0] ro;
    logic [31:0] rd;
    logic [4:0] rs;
    tbl[0] = '{3'd1, 32'h0000_0001, 5'd4, 32'h0000_0010};
    tbl[1] = '{3'd3, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    tbl[2] = '{3'd2, 32'h8000_0000, 5'd31, 32'h0000_0001};
    tbl[3] = '{3'd2, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF};
    tbl[4] = '{3'd0, 32'h1234_5678, 5'd7, 32'h1234_5678};
    tbl[5] = '{3'd6, 32'hA5A5_A5A5, 5'd3, 32'hA5A5_A5A5};
`ifdef ITER_SHIFT_ROTATE_EN
    tbl[6] = '{3'd5, 32'h0000_0001, 5'd1, 32'h8000_0000};
    tbl[7] = '{3'd4, 32'h8000_0001, 5'd4, 32'h0000_0018};
`else
    tbl[6] = '{3'd5, 32'h0000_0001, 5'd1, 32'h0000_0001};
    tbl[7] = '{3'd4, 32'h8000_0001, 5'd4, 32'h8000_0001};
`endif
    #12;
    chk("reset state", {busy, done, data_out}, 0);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 8; i++) run(tbl[i].op, tbl[i].d, tbl[i].sh, tbl[i].exp, $sformatf("vec%0d", i));

    // reset mid-operation
    @(negedge clk);
    op = 3'd1; data_in = 32'h0000_0003; shamt = 5'd10; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    #2 reset = 1;
    #1 chk("mid reset", {busy, done, data_out}, 0);
    @(negedge clk);
    reset = 0;
    pulses = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("no done after reset", pulses, 0);

    // start while busy is ignored
    @(negedge clk);
    op = 3'd1; data_in = 32'h0000_0003; shamt = 5'd2; start = 1;
    @(negedge clk);
    op = 3'd2; data_in = 32'hFFFF_FFFF; shamt = 5'd7;
    @(negedge clk);
    start = 0;
    pulses = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("ignored start pulses", pulses, 1);
    chk("ignored start data", data_out, 32'h0000_000C);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom);
      rd = $urandom;
      rs = 5'($urandom);
      run(ro, rd, rs, model(ro, rd, int'(rs)), $sformatf("rand%0d op%0d sh%0d", i, ro, rs));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
